// File: rtl/alu_seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock behind a start/busy/done handshake.
// Quotient, remainder and dbz are held between operations for the ALU result mux.
module alu_seq_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         dbz
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  prem_q, prem_d;
  logic [N-1:0]  wq_q, wq_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [N:0]    shifted;
  logic [N:0]    trial;
  logic          neg;
  logic [N-1:0]  prem_next;
  logic [N-1:0]  wq_next;

  // One restoring step. shifted < 2b, so trial lies in [-b, b-1] and its
  // N+1-bit two's-complement sign bit is exact.
  always_comb begin
    shifted   = {prem_q, wq_q[N-1]};
    trial     = shifted - {1'b0, b_q};
    neg       = trial[N];
    prem_next = neg ? shifted[N-1:0] : trial[N-1:0];
    wq_next   = {wq_q[N-2:0], ~neg};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    wq_d    = wq_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            b_d     = divisor;
            wq_d    = dividend;
            prem_d  = '0;
            cnt_d   = CW'(N);
            state_d = S_RUN;
          end else begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        prem_d = prem_next;
        wq_d   = wq_next;
        cnt_d  = cnt_q - CW'(1);
        // Last iteration publishes straight from the step logic so done
        // lines up with the final quotient bit.
        if (cnt_q == CW'(1)) begin
          quo_d   = wq_next;
          rem_d   = prem_next;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      wq_q    <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      wq_q    <= wq_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_alu_seq_divider.sv
// Directed and randomized bench for alu_seq_divider (N=4) against an arithmetic reference model.
module tb_alu_seq_divider;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         dbz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         d;
    int           gap;
  } exp_t;

  exp_t expq[$];

  alu_seq_divider #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = '1; e.r = a; e.d = 1'b1; e.gap = 2;
    end else begin
      e.q = a / b; e.r = a % b; e.d = 1'b0; e.gap = N + 2;
    end
    return e;
  endfunction

  // Starts one operation from IDLE and follows it to completion.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
    exp_t e;
    int idx;
    int busy_n;
    bit seen;
    e = model(a, b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    idx = 1; busy_n = 0; seen = 0;
    while (!seen && idx <= 20) begin
      if (busy) busy_n++;
      if (done) seen = 1;
      else begin
        @(negedge clk);
        idx++;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, idx, (b == 0) ? 1 : N + 1);
    chk({tag, "_busy_cycles"}, busy_n, (b == 0) ? 1 : N + 1);
    chk({tag, "_quotient"}, 32'(quotient), 32'(e.q));
    chk({tag, "_remainder"}, 32'(remainder), 32'(e.r));
    chk({tag, "_dbz"}, 32'(dbz), 32'(e.d));
    @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_hold_quotient"}, 32'(quotient), 32'(e.q));
  endtask

  initial begin
    logic [7:0] pairs[256];
    logic [7:0] tmp;
    exp_t e;
    int sent, got, cyc, last_done;
    bit stray_done;

    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_dbz", 32'(dbz), 32'd0);
    rst = 1'b0;

    run_op(4'd13, 4'd4, "div13_4");
    run_op(4'd15, 4'd1, "div15_1");
    run_op(4'd3, 4'd7, "div3_7");
    run_op(4'd0, 4'd5, "div0_5");
    run_op(4'd9, 4'd0, "div9_0");

    // Start ignored while busy: 12/5 with intruding 2/1 starts in RUN and DONE.
    @(negedge clk);
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("ign_run_hold_quotient", 32'(quotient), 32'hF);
    chk("ign_run_hold_remainder", 32'(remainder), 32'd9);
    chk("ign_run_hold_dbz", 32'(dbz), 32'd1);
    start = 1'b1; dividend = 4'd2; divisor = 4'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_quotient", 32'(quotient), 32'd2);
    chk("ign_remainder", 32'(remainder), 32'd2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("ign_not_launched", 32'(busy), 32'd0);
    run_op(4'd2, 4'd1, "after_ign");

    // Reset mid-RUN aborts with no done and no result update.
    run_op(4'd7, 4'd2, "div7_2");
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_dbz", 32'(dbz), 32'd0);
    stray_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) stray_done = 1;
    end
    chk("abort_no_done", 32'(stray_done), 32'd0);
    run_op(4'd14, 4'd3, "div14_3");

    // Back-to-back sweep of every (a, b) pair in random order with start held high.
    for (int i = 0; i < 256; i++) pairs[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int j;
      j = $urandom_range(i, 0);
      tmp = pairs[i]; pairs[i] = pairs[j]; pairs[j] = tmp;
    end
    sent = 0; got = 0; cyc = 0; last_done = -1;
    @(negedge clk);
    while (got < 256 && cyc < 256 * (N + 2) + 100) begin
      if (done) begin
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("sweep_quotient", 32'(quotient), 32'(e.q));
          chk("sweep_remainder", 32'(remainder), 32'(e.r));
          chk("sweep_dbz", 32'(dbz), 32'(e.d));
          if (last_done >= 0) chk("sweep_done_gap", cyc - last_done, e.gap);
        end else begin
          chk("sweep_unexpected_done", 32'd1, 32'd0);
        end
        last_done = cyc;
        got++;
      end
      if (!busy) begin
        if (sent < 256) begin
          start = 1'b1;
          dividend = pairs[sent][7:4];
          divisor = pairs[sent][3:0];
          expq.push_back(model(pairs[sent][7:4], pairs[sent][3:0]));
          sent++;
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("sweep_all_done", got, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
